// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// operation encodings, FSM states and operand-signedness helpers.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_DONE
    } state_t;

    // rs1 is treated as signed for every op except the fully unsigned ones
    function automatic logic a_is_signed(input logic [2:0] op);
        return (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide over XLEN cycles, with a one-cycle fast path for div-by-zero/overflow.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [XLEN-1:0] res,
    output logic            res_valid,
    input  logic            res_ready
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_reg, state_next;
    logic [2:0]      op_reg;
    logic [XLEN-1:0] a_reg, b_reg;
    logic [XLEN-1:0] opnd_reg;
    logic [XLEN-1:0] hi_reg, lo_reg;
    logic            neg_reg, rneg_reg;
    logic [CW-1:0]   cnt_reg;
    logic [XLEN-1:0] res_reg;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        a_neg    = a_is_signed(op_reg) && a_reg[XLEN-1];
        b_neg    = b_is_signed(op_reg) && b_reg[XLEN-1];
        a_mag    = a_neg ? -a_reg : a_reg;
        b_mag    = b_neg ? -b_reg : b_reg;
        div_zero = op_reg[2] && (b_reg == '0);
        div_ovf  = op_reg[2] && !op_reg[0] && (a_reg == MIN_NEG) && (b_reg == '1);
        special  = div_zero || div_ovf;
        // op_reg[1] distinguishes REM/REMU from DIV/DIVU within the divide group
        if (div_zero) begin
            special_res = op_reg[1] ? a_reg : '1;
        end else begin
            special_res = op_reg[1] ? '0 : a_reg;
        end
    end

    // One iteration: multiply keeps {hi,lo} as the partial product with the
    // multiplier shifting out of lo; divide keeps hi as the partial remainder
    // and lo as dividend bits shifting out while quotient bits shift in.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_shift;
    logic            rem_ge;
    logic [XLEN-1:0] rem_diff;
    logic [XLEN-1:0] hi_next, lo_next;
    logic            last_iter;

    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
        rem_shift = {hi_reg, lo_reg[XLEN-1]};
        rem_ge    = rem_shift >= {1'b0, opnd_reg};
        rem_diff  = rem_shift[XLEN-1:0] - opnd_reg;
        if (op_reg[2]) begin
            hi_next = rem_ge ? rem_diff : rem_shift[XLEN-1:0];
            lo_next = {lo_reg[XLEN-2:0], rem_ge};
        end else begin
            hi_next = mul_sum[XLEN:1];
            lo_next = {mul_sum[0], lo_reg[XLEN-1:1]};
        end
        last_iter = (cnt_reg == CW'(XLEN - 1));
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, calc_res;

    always_comb begin
        prod = neg_reg ? -{hi_next, lo_next} : {hi_next, lo_next};
        quo  = neg_reg ? -lo_next : lo_next;
        rem  = rneg_reg ? -hi_next : hi_next;
        case (op_reg)
            OP_MUL:                      calc_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             calc_res = quo;
            default:                     calc_res = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        res_valid  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_PREP;
            end
            ST_PREP: state_next = special ? ST_DONE : ST_CALC;
            ST_CALC: if (last_iter) state_next = ST_DONE;
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg   <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            opnd_reg <= '0;
            hi_reg   <= '0;
            lo_reg   <= '0;
            neg_reg  <= 1'b0;
            rneg_reg <= 1'b0;
            cnt_reg  <= '0;
            res_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_reg <= op;
                        a_reg  <= a;
                        b_reg  <= b;
                    end
                end
                ST_PREP: begin
                    hi_reg   <= '0;
                    lo_reg   <= op_reg[2] ? a_mag : b_mag;
                    opnd_reg <= op_reg[2] ? b_mag : a_mag;
                    neg_reg  <= a_neg ^ b_neg;
                    rneg_reg <= a_neg;
                    cnt_reg  <= '0;
                    if (special) res_reg <= special_res;
                end
                ST_CALC: begin
                    hi_reg  <= hi_next;
                    lo_reg  <= lo_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (last_iter) res_reg <= calc_res;
                end
                default: ;
            endcase
        end
    end

    assign res = res_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, latency, stall,
// ignored-request and reset-abort scenarios.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN     = 32;
    localparam int LAT_NORM = XLEN + 2;
    localparam int LAT_FAST = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      op;
    logic [XLEN-1:0] a, b;
    logic            in_valid, in_ready;
    logic [XLEN-1:0] res;
    logic            res_valid, res_ready;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res       (res),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    typedef struct {
        string           name;
        logic [XLEN-1:0] exp;
        int              t;
        int              lat;
    } txn_t;

    txn_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge and retires results from the queue
    logic            holding = 1'b0;
    logic [XLEN-1:0] held;

    always @(negedge clk) begin
        if (!rst) begin
            if (sbq.size() > 0 && !holding && !res_valid && cyc > sbq[0].t)
                chk({sbq[0].name, " in_ready busy"}, 32'(in_ready), 32'd0);
            if (res_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected res_valid", 32'(res_valid), 32'd0);
                end else begin
                    if (!holding) begin
                        holding = 1'b1;
                        held    = res;
                        chk({sbq[0].name, " latency"}, 32'(cyc - sbq[0].t), 32'(sbq[0].lat));
                        chk({sbq[0].name, " in_ready done"}, 32'(in_ready), 32'd0);
                    end else begin
                        chk({sbq[0].name, " res stable"}, res, held);
                    end
                    if (res_ready) begin
                        $display("txn %-8s res=0x%08h exp=0x%08h latency=%0d",
                                 sbq[0].name, res, sbq[0].exp, cyc - sbq[0].t);
                        chk(sbq[0].name, res, sbq[0].exp);
                        void'(sbq.pop_front());
                        holding = 1'b0;
                    end
                end
            end
        end
    end

    task automatic issue(input string name, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int lat,
                         input bit push);
        int t;
        @(negedge clk);
        for (int n = 0; n < 100 && !in_ready; n++) @(negedge clk);
        chk({name, " in_ready idle"}, 32'(in_ready), 32'd1);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        t        = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) sbq.push_back('{name: name, exp: exp, t: t, lat: lat});
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && sbq.size() != 0; n++) @(negedge clk);
        chk("drain timeout", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        op        = OP_MUL;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset res_valid", 32'(res_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset res", res, 32'd0);
        rst = 1'b0;

        // Back-to-back directed vectors
        issue("MUL",    OP_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, LAT_NORM, 1);
        issue("MULH",   OP_MULH,   32'h80000000,   32'h80000000, 32'h40000000, LAT_NORM, 1);
        issue("MULHU",  OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, LAT_NORM, 1);
        issue("MULHSU", OP_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, LAT_NORM, 1);
        issue("MULHn",  OP_MULH,   32'hFFFFFFFF,   32'd5,        32'hFFFFFFFF, LAT_NORM, 1);
        issue("DIV",    OP_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, LAT_NORM, 1);
        issue("REM",    OP_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, LAT_NORM, 1);
        issue("DIVU",   OP_DIVU,   32'd100,        32'd7,        32'd14,       LAT_NORM, 1);
        issue("REMU",   OP_REMU,   32'd100,        32'd7,        32'd2,        LAT_NORM, 1);
        issue("DIVneg", OP_DIV,    32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, LAT_NORM, 1);
        issue("REMneg", OP_REM,    32'd7,          32'hFFFFFFFE, 32'd1,        LAT_NORM, 1);
        issue("DIVU/0", OP_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, LAT_FAST, 1);
        issue("REMU/0", OP_REMU,   32'd5,          32'd0,        32'd5,        LAT_FAST, 1);
        issue("DIV/0",  OP_DIV,    32'hFFFFFFF8,   32'd0,        32'hFFFFFFFF, LAT_FAST, 1);
        issue("REM/0",  OP_REM,    32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9, LAT_FAST, 1);
        issue("DIVovf", OP_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, LAT_FAST, 1);
        issue("REMovf", OP_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        LAT_FAST, 1);
        drain();

        // Consumer stall in DONE: result must hold
        res_ready = 1'b0;
        issue("stall", OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_NORM, 1);
        for (int n = 0; n < 100 && !res_valid; n++) begin
            @(posedge clk);
            #1;
        end
        repeat (5) @(posedge clk);
        #1;
        chk("stall res_valid held", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        drain();

        // in_valid pulsed during CALC must be ignored
        issue("busy", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, LAT_NORM, 1);
        repeat (5) @(negedge clk);
        op       = OP_MUL;
        a        = 32'd1;
        b        = 32'd1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        drain();
        repeat (40) @(negedge clk);
        chk("busy no extra", 32'(res_valid), 32'd0);

        // Reset at CALC iteration 10 aborts the operation
        issue("abort", OP_MUL, 32'd5, 32'd5, 32'd25, LAT_NORM, 0);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort res_valid", 32'(res_valid), 32'd0);
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort res", res, 32'd0);
        op       = OP_MUL;
        a        = 32'd9;
        b        = 32'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rst over accept", 32'(in_ready), 32'd1);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort no result", 32'(res_valid), 32'd0);

        issue("MUL3x4", OP_MUL, 32'd3, 32'd4, 32'd12, LAT_NORM, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width; iteration count equals XLEN.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port op  input  3  operation, equal to RV32M func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port a  input  XLEN  rs1 operand (multiplicand / dividend).
REQ-006 SHALL have port b  input  XLEN  rs2 operand (multiplier / divisor).
REQ-007 SHALL have port in_valid  input  1  request present; op/a/b sampled when in_valid and in_ready are both high.
REQ-008 SHALL have port in_ready  output  1  unit can accept a request; high only in IDLE.
REQ-009 SHALL have port res  output  XLEN  result, stable while res_valid is high.
REQ-010 SHALL have port res_valid  output  1  result available.
REQ-011 SHALL have port res_ready  input  1  consumer accepts res; transfer occurs when res_valid and res_ready are both high.

Function
REQ-012 SHALL implement states IDLE, PREP, CALC, DONE; IDLE->PREP on accept; PREP->CALC normally, PREP->DONE on special case; CALC->DONE after XLEN iterations; DONE->IDLE on transfer.
REQ-013 SHALL, in PREP, latch operand magnitudes and the result-sign flag: MUL/MULH/DIV/REM use both operands signed, MULHSU uses a signed and b unsigned, MULHU/DIVU/REMU use both unsigned.
REQ-014 SHALL compute multiplication as a radix-2 shift-add over XLEN CALC cycles into a 2*XLEN-bit product, negated at the end if the result sign is negative.
REQ-015 SHALL compute division as radix-2 restoring shift-subtract over XLEN CALC cycles; the quotient is negated if operand signs differ (signed ops), and the remainder takes the dividend's sign.
REQ-016 SHALL select res as follows: MUL gives product[XLEN-1:0]; MULH/MULHSU/MULHU give product[2XLEN-1:XLEN]; DIV/DIVU give the quotient; REM/REMU give the remainder.
REQ-017 SHALL handle divide by zero (b==0, div ops) via the PREP->DONE fast path: the quotient is all ones and the remainder is a unchanged.
REQ-018 SHALL handle signed overflow (DIV/REM, a==2^(XLEN-1) negative, b==-1) via the fast path: the quotient is a and the remainder is 0.
REQ-019 SHALL meet these latencies, where the accept edge ends cycle T: normal ops assert res_valid in cycle T+XLEN+2 (T+34); fast-path ops assert it in cycle T+2.
REQ-020 SHALL hold res and res_valid unchanged in DONE while res_ready is low, with no result dropped or overwritten.
REQ-021 SHALL ignore in_valid when not in IDLE; there is no accept in the same cycle as a DONE transfer, and the next accept is possible in the first IDLE cycle.
REQ-022 SHALL leave res holding its last value in IDLE/PREP/CALC, ignored by the consumer since res_valid is low.

Reset
REQ-023 SHALL, with rst high at an edge, go to IDLE and set res_valid=0, in_ready=1 (from the following cycle), and res=0, regardless of state.
REQ-024 SHALL abort an in-flight operation on rst in PREP/CALC/DONE, discarding its result; no res_valid pulse follows.
REQ-025 SHALL give rst priority over an in_valid accept in the same cycle.

Structure
REQ-026 SHALL place in the shared package muldiv_pkg: op encodings (localparams matching func3), the state enumeration, and the XLEN default.
REQ-027 SHALL be a single module with no sub-module; the iteration counter is $clog2(XLEN)+1 bits wide.

Verification
REQ-028 SHALL cover: MUL a=7, b=0xFFFFFFFD -> res=0xFFFFFFEB, res_valid in cycle T+34, in_ready low T+1..T+34.
REQ-029 SHALL cover: MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-030 SHALL cover: DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-031 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both at T+2; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-032 SHALL cover: res_ready held low 5 cycles in DONE -> res stable, in_ready low; in_valid pulsed during CALC -> ignored, no extra result.
REQ-033 SHALL cover: rst asserted at CALC iteration 10 -> next cycle IDLE, res_valid=0, in_ready=1; a new MUL 3*4 -> 12 completes normally.
